neuron_layer_sequencer: RTL and testbench

//  Time-multiplexes one shared 32-bit signed multiply/add/ReLU datapath across NUM_NEURONS
//  2-input neurons: f = ReLU(w1*x1 + w2*x2 + b). Holds per-neuron weights and biases in a

---
 rtl/neuron_layer_sequencer.sv | 207 ++++++++++++++++++++
 tb/tb_neuron_layer_sequencer.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/neuron_layer_sequencer.sv
// neuron_layer_sequencer: shares one multiply/add/ReLU datapath across NUM_NEURONS
// 2-input neurons, f = ReLU(w1*x1 + w2*x2 + b), one result streamed per neuron.
//
// Optional build macro: NEURON_SEQ_SAT_EN
//   defined   -> every product (formed at 64 bits) and every addition saturates
//                to [-2^31, 2^31-1]
//   undefined -> two's complement wrap-around at 32 bits
//
// Ports:
//   clk, rst_n          clock, synchronous active-low reset
//   cfg_we/idx/sel/data weight/bias write port (sel 0=w1, 1=w2, 2=b, 3=reserved);
//                       only accepted in IDLE with a valid index and selector
//   in_valid/in_ready   input vector handshake, in_x1/in_x2 signed operands
//   out_valid/out_ready result handshake, out_f (>=0), out_idx, out_last
//   busy                high whenever a vector is being processed
module neuron_layer_sequencer #(
    parameter int NUM_NEURONS = 4,
    parameter int IDX_W       = $clog2(NUM_NEURONS) + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cfg_we,
    input  logic [IDX_W-1:0] cfg_idx,
    input  logic [1:0]       cfg_sel,
    input  logic [31:0]      cfg_data,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_x1,
    input  logic [31:0]      in_x2,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_f,
    output logic [IDX_W-1:0] out_idx,
    output logic             out_last,
    output logic             busy
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_MUL1,
        S_MUL2,
        S_BIAS,
        S_OUT
    } state_t;

    localparam logic [IDX_W-1:0] LAST = IDX_W'(NUM_NEURONS - 1);

`ifdef NEURON_SEQ_SAT_EN
    localparam logic signed [63:0] MAX64 = 64'sd2147483647;
    localparam logic signed [63:0] MIN64 = -64'sd2147483648;

    function automatic logic signed [31:0] mul32(input logic signed [31:0] a,
                                                 input logic signed [31:0] b);
        logic signed [63:0] p;
        p = a * b;
        if (p > MAX64)
            return 32'sh7fff_ffff;
        else if (p < MIN64)
            return 32'sh8000_0000;
        else
            return p[31:0];
    endfunction

    function automatic logic signed [31:0] add32(input logic signed [31:0] a,
                                                 input logic signed [31:0] b);
        logic [32:0] s;
        s = {a[31], a} + {b[31], b};
        // Sign bits disagree only when the 32-bit result overflowed.
        if (s[32] != s[31])
            return s[32] ? 32'sh8000_0000 : 32'sh7fff_ffff;
        else
            return s[31:0];
    endfunction
`else
    function automatic logic signed [31:0] mul32(input logic signed [31:0] a,
                                                 input logic signed [31:0] b);
        return a * b;
    endfunction

    function automatic logic signed [31:0] add32(input logic signed [31:0] a,
                                                 input logic signed [31:0] b);
        return a + b;
    endfunction
`endif

    state_t state, nxt;

    logic signed [31:0] w1 [NUM_NEURONS];
    logic signed [31:0] w2 [NUM_NEURONS];
    logic signed [31:0] bs [NUM_NEURONS];

    logic signed [31:0] x1, x2, acc;
    logic [IDX_W-1:0]   idx;

    logic signed [31:0] w1_cur, w2_cur, b_cur;
    logic signed [31:0] prod1, sum2, bsum;
    logic               cfg_ok;

    assign in_ready = (state == S_IDLE);
    assign busy     = (state != S_IDLE);
    assign cfg_ok   = cfg_we && (state == S_IDLE) &&
                      (cfg_idx <= LAST) && (cfg_sel != 2'd3);

    // Neuron select mux; comparing against full-width idx avoids
    // truncating the index when NUM_NEURONS is not a power of two.
    always_comb begin
        w1_cur = '0;
        w2_cur = '0;
        b_cur  = '0;
        for (int i = 0; i < NUM_NEURONS; i++) begin
            if (idx == IDX_W'(i)) begin
                w1_cur = w1[i];
                w2_cur = w2[i];
                b_cur  = bs[i];
            end
        end
    end

    always_comb begin
        prod1 = mul32(w1_cur, x1);
        sum2  = add32(acc, mul32(w2_cur, x2));
        bsum  = add32(acc, b_cur);
    end

    always_ff @(posedge clk) begin
        if (!rst_n)
            state <= S_IDLE;
        else
            state <= nxt;
    end

    always_comb begin
        nxt = state;
        case (state)
            S_IDLE:  if (in_valid) nxt = S_MUL1;
            S_MUL1:  nxt = S_MUL2;
            S_MUL2:  nxt = S_BIAS;
            S_BIAS:  nxt = S_OUT;
            S_OUT:   if (out_ready) nxt = out_last ? S_IDLE : S_MUL1;
            default: nxt = S_IDLE;
        endcase
    end

    // Config register file. A write landing on the accept edge is
    // visible to MUL1 on the following cycle.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_NEURONS; i++) begin
                w1[i] <= '0;
                w2[i] <= '0;
                bs[i] <= '0;
            end
        end else if (cfg_ok) begin
            for (int i = 0; i < NUM_NEURONS; i++) begin
                if (cfg_idx == IDX_W'(i)) begin
                    case (cfg_sel)
                        2'd0:    w1[i] <= cfg_data;
                        2'd1:    w2[i] <= cfg_data;
                        2'd2:    bs[i] <= cfg_data;
                        default: ;
                    endcase
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            x1        <= '0;
            x2        <= '0;
            acc       <= '0;
            idx       <= '0;
            out_f     <= '0;
            out_idx   <= '0;
            out_last  <= 1'b0;
            out_valid <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (in_valid) begin
                        x1  <= in_x1;
                        x2  <= in_x2;
                        idx <= '0;
                    end
                end
                S_MUL1: acc <= prod1;
                S_MUL2: acc <= sum2;
                S_BIAS: begin
                    out_f     <= bsum[31] ? 32'd0 : bsum;
                    out_idx   <= idx;
                    out_last  <= (idx == LAST);
                    out_valid <= 1'b1;
                end
                S_OUT: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        out_last  <= 1'b0;
                        if (!out_last)
                            idx <= idx + IDX_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_neuron_layer_sequencer.sv
// tb_neuron_layer_sequencer: directed + randomized checks of neuron_layer_sequencer
// against an arithmetic reference model of the layer.
module tb_neuron_layer_sequencer;

    localparam int NN    = 4;
    localparam int IDX_W = $clog2(NN) + 1;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             cfg_we;
    logic [IDX_W-1:0] cfg_idx;
    logic [1:0]       cfg_sel;
    logic [31:0]      cfg_data;
    logic             in_valid;
    logic             in_ready;
    logic [31:0]      in_x1;
    logic [31:0]      in_x2;
    logic             out_valid;
    logic             out_ready;
    logic [31:0]      out_f;
    logic [IDX_W-1:0] out_idx;
    logic             out_last;
    logic             busy;

    int tests  = 0;
    int failed = 0;
    int cyc    = 0;

    int mw1 [NN];
    int mw2 [NN];
    int mb  [NN];
    int got [NN];

    neuron_layer_sequencer #(.NUM_NEURONS(NN)) dut (
        .clk(clk), .rst_n(rst_n),
        .cfg_we(cfg_we), .cfg_idx(cfg_idx), .cfg_sel(cfg_sel), .cfg_data(cfg_data),
        .in_valid(in_valid), .in_ready(in_ready), .in_x1(in_x1), .in_x2(in_x2),
        .out_valid(out_valid), .out_ready(out_ready), .out_f(out_f),
        .out_idx(out_idx), .out_last(out_last), .busy(busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic int clamp(input longint v);
`ifdef NEURON_SEQ_SAT_EN
        if (v > 64'sd2147483647) return 32'h7fffffff;
        if (v < -64'sd2147483648) return 32'h80000000;
`endif
        return int'(v);
    endfunction

    function automatic int model(input int n, input int a, input int b);
        int p1, p2, s;
        p1 = clamp(longint'(mw1[n]) * longint'(a));
        p2 = clamp(longint'(mw2[n]) * longint'(b));
        s  = clamp(longint'(p1) + longint'(p2));
        s  = clamp(longint'(s) + longint'(mb[n]));
        return (s < 0) ? 0 : s;
    endfunction

    task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] e);
        tests++;
        assert (o === e) else begin
            failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, o, e);
        end
    endtask

    task automatic model_wr(input int idx, input int sel, input int data);
        if (idx >= 0 && idx < NN && sel != 3) begin
            case (sel)
                0: mw1[idx] = data;
                1: mw2[idx] = data;
                default: mb[idx] = data;
            endcase
        end
    endtask

    task automatic cfg(input int idx, input int sel, input int data);
        @(negedge clk);
        cfg_we   = 1'b1;
        cfg_idx  = IDX_W'(idx);
        cfg_sel  = 2'(sel);
        cfg_data = data;
        @(negedge clk);
        cfg_we = 1'b0;
        model_wr(idx, sel, data);
    endtask

    task automatic cfg_rand();
        for (int n = 0; n < NN; n++) begin
            for (int s = 0; s < 3; s++) begin
                if ($urandom_range(1, 0) == 1)
                    cfg(n, s, int'($urandom));
                else
                    cfg(n, s, int'($urandom_range(200, 0)) - 100);
            end
        end
    endtask

    task automatic run_vec(input int x1, input int x2, input int stall,
                           input bit busy_wr, input bit sw,
                           input int sw_idx, input int sw_data);
        int ex [NN];
        int t_exp;
        int k;
        if (sw) model_wr(sw_idx, 0, sw_data);
        for (int n = 0; n < NN; n++) ex[n] = model(n, x1, x2);
        out_ready = 1'b1;
        @(negedge clk);
        chk("accept_ready", 32'(in_ready), 32'd1);
        in_valid = 1'b1;
        in_x1    = x1;
        in_x2    = x2;
        if (sw) begin
            cfg_we   = 1'b1;
            cfg_idx  = IDX_W'(sw_idx);
            cfg_sel  = 2'd0;
            cfg_data = sw_data;
        end
        @(negedge clk);
        in_valid = 1'b0;
        cfg_we   = 1'b0;
        t_exp    = cyc + 3;
        if (busy_wr) begin
            cfg_we   = 1'b1;
            cfg_idx  = '0;
            cfg_sel  = 2'd0;
            cfg_data = $urandom;
        end
        for (int n = 0; n < NN; n++) begin
            out_ready = (n != stall);
            k = 0;
            while (!out_valid && k < 20) begin
                @(negedge clk);
                k++;
            end
            chk($sformatf("valid%0d", n), 32'(out_valid), 32'd1);
            chk($sformatf("arrive%0d", n), cyc, t_exp);
            chk($sformatf("f%0d", n), out_f, ex[n]);
            chk($sformatf("idx%0d", n), 32'(out_idx), n);
            chk($sformatf("last%0d", n), 32'(out_last), 32'(n == NN - 1));
            chk($sformatf("rdy_busy%0d", n), 32'(in_ready), 32'd0);
            chk($sformatf("busy%0d", n), 32'(busy), 32'd1);
            got[n] = out_f;
            if (n == NN - 1) cfg_we = 1'b0;
            if (n == stall) begin
                repeat (5) begin
                    @(negedge clk);
                    chk("stall_valid", 32'(out_valid), 32'd1);
                    chk("stall_f", out_f, ex[n]);
                    chk("stall_idx", 32'(out_idx), n);
                    chk("stall_rdy", 32'(in_ready), 32'd0);
                end
                out_ready = 1'b1;
            end
            t_exp = cyc + 4;
            @(negedge clk);
        end
        chk("done_busy", 32'(busy), 32'd0);
        chk("done_valid", 32'(out_valid), 32'd0);
        chk("done_ready", 32'(in_ready), 32'd1);
    endtask

    initial begin
        rst_n     = 1'b0;
        cfg_we    = 1'b0;
        cfg_idx   = '0;
        cfg_sel   = '0;
        cfg_data  = '0;
        in_valid  = 1'b0;
        in_x1     = '0;
        in_x2     = '0;
        out_ready = 1'b1;
        for (int n = 0; n < NN; n++) begin
            mw1[n] = 0;
            mw2[n] = 0;
            mb[n]  = 0;
        end
        repeat (3) @(negedge clk);
        chk("rst_valid", 32'(out_valid), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_ready", 32'(in_ready), 32'd1);
        chk("rst_f", out_f, 32'd0);
        chk("rst_idx", 32'(out_idx), 32'd0);
        chk("rst_last", 32'(out_last), 32'd0);
        rst_n = 1'b1;

        // Basic neurons 0 and 1, random 2 and 3.
        cfg_rand();
        cfg(0, 0, 2);
        cfg(0, 1, 3);
        cfg(0, 2, 1);
        cfg(1, 0, -4);
        cfg(1, 1, 0);
        cfg(1, 2, 2);
        run_vec(5, -1, -1, 1'b0, 1'b0, 0, 0);
        chk("t1_f0", got[0], 32'd8);
        chk("t2_f1", got[1], 32'd0);

        // Backpressure on idx 1 with random vector.
        run_vec(int'($urandom), int'($urandom_range(50, 0)) - 25, 1,
                1'b0, 1'b0, 0, 0);

        // Randomized configurations and vectors.
        repeat (3) begin
            cfg_rand();
            run_vec(int'($urandom), int'($urandom), int'($urandom_range(NN - 1, 0)),
                    1'b0, 1'b0, 0, 0);
        end

        // Product overflow.
        cfg(0, 0, 32'h40000000);
        cfg(0, 1, 0);
        cfg(0, 2, 7);
        run_vec(4, int'($urandom), -1, 1'b0, 1'b0, 0, 0);
`ifdef NEURON_SEQ_SAT_EN
        chk("ovf_f0", got[0], 32'h7fffffff);
`else
        chk("ovf_f0", got[0], 32'd7);
`endif

        // Dropped writes: bad index, reserved selector, write while busy.
        cfg(NN, 0, 123);
        cfg(1, 3, 555);
        run_vec(int'($urandom_range(100, 0)), int'($urandom_range(100, 0)), -1,
                1'b1, 1'b0, 0, 0);
        run_vec(int'($urandom_range(100, 0)), int'($urandom_range(100, 0)), -1,
                1'b0, 1'b0, 0, 0);

        // Same-edge w1 write and accept.
        run_vec(int'($urandom_range(100, 0)), int'($urandom_range(100, 0)), -1,
                1'b0, 1'b1, 2, int'($urandom_range(1000, 1)));

        // Reset during MUL2 of idx 2.
        out_ready = 1'b1;
        @(negedge clk);
        in_valid = 1'b1;
        in_x1    = 3;
        in_x2    = 4;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (9) @(negedge clk);
        chk("mid_busy", 32'(busy), 32'd1);
        chk("mid_idx", 32'(out_idx), 32'd1);
        rst_n = 1'b0;
        @(negedge clk);
        chk("rst2_valid", 32'(out_valid), 32'd0);
        chk("rst2_busy", 32'(busy), 32'd0);
        chk("rst2_ready", 32'(in_ready), 32'd1);
        chk("rst2_f", out_f, 32'd0);
        rst_n = 1'b1;
        for (int n = 0; n < NN; n++) begin
            mw1[n] = 0;
            mw2[n] = 0;
            mb[n]  = 0;
        end
        run_vec(int'($urandom), int'($urandom), -1, 1'b0, 1'b0, 0, 0);
        for (int n = 0; n < NN; n++)
            chk($sformatf("zero_f%0d", n), got[n], 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
